// File: rtl/avmm_dualport_onchip_ram_if.sv
// avmm_dualport_onchip_ram_if: one Avalon-MM slave port of the dual-port on-chip RAM
interface avmm_dualport_onchip_ram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0]   address;
    logic                    chipselect;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;
    logic                    oor;
    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid, oor
    );
    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid, oor
    );
endinterface

// File: rtl/avmm_dualport_onchip_ram.sv
// avmm_dualport_onchip_ram: two-port Avalon-MM RAM with 1/2-cycle read latency, OOR flag and s1-priority byte-lane collision rule
module avmm_dualport_onchip_ram #(
    parameter int    DATA_WIDTH   = 32,
    parameter int    DEPTH        = 45000,
    parameter int    ADDR_WIDTH   = 16,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "UNUSED"
) (
    input logic                       clk,
    input logic                       reset,
    input logic                       reset_req,
    input logic                       clken,
    avmm_dualport_onchip_ram_if.slave s1,
    avmm_dualport_onchip_ram_if.slave s2
);
    localparam int                  NB      = DATA_WIDTH / 8;
    localparam int                  IW      = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end
    if (INIT_FILE != "UNUSED") begin : g_init_ignored
        $warning("INIT_FILE is ignored: preload the RAM through s2");
    end

    logic                         clocken;
    logic [DATA_WIDTH-1:0]        mem [DEPTH];
    logic [1:0][ADDR_WIDTH-1:0]   addr;
    logic [1:0][NB-1:0]           be;
    logic [1:0][DATA_WIDTH-1:0]   wd;
    logic [1:0]                   rd_req;
    logic [1:0]                   wr_req;
    logic [1:0]                   in_rng;
    logic [1:0][DATA_WIDTH-1:0]   rd_d;
    logic [1:0]                   in_v;
    logic [1:0]                   in_o;
    logic [1:0][DATA_WIDTH-1:0]   in_d;
    logic [1:0]                   ov_q;
    logic [1:0]                   oo_q;
    logic [1:0][DATA_WIDTH-1:0]   od_q;

    assign clocken = clken & ~reset_req;
    assign addr    = {s2.address, s1.address};
    assign be      = {s2.byteenable, s1.byteenable};
    assign wd      = {s2.writedata, s1.writedata};
    assign wr_req  = {s2.chipselect & s2.write, s1.chipselect & s1.write};
    assign rd_req  = {s2.chipselect & s2.read & ~s2.write, s1.chipselect & s1.read & ~s1.write};

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            in_rng[p] = {1'b0, addr[p]} < DEPTH_W;
            rd_d[p]   = in_rng[p] ? mem[addr[p][IW-1:0]] : '0;
        end
    end

    // s2 is applied first so s1 overwrites any lane both ports enable
    always_ff @(posedge clk) begin
        if (clocken && !reset) begin
            for (int p = 1; p >= 0; p--) begin
                if (wr_req[p] && in_rng[p]) begin
                    for (int b = 0; b < NB; b++) begin
                        if (be[p][b]) mem[addr[p][IW-1:0]][8*b +: 8] <= wd[p][8*b +: 8];
                    end
                end
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [1:0]                 pv_q;
        logic [1:0]                 po_q;
        logic [1:0][DATA_WIDTH-1:0] pd_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                pv_q <= '0;
                po_q <= '0;
                pd_q <= '0;
            end else if (clocken) begin
                pv_q <= rd_req;
                po_q <= ~in_rng;
                pd_q <= rd_d;
            end
        end
        assign in_v = pv_q;
        assign in_o = po_q;
        assign in_d = pd_q;
    end else begin : g_lat1
        assign in_v = rd_req;
        assign in_o = ~in_rng;
        assign in_d = rd_d;
    end

    // output stage holds through stalls; valid is masked so a stalled result shows once, on resume
    always_ff @(posedge clk) begin
        if (reset) begin
            ov_q <= '0;
            oo_q <= '0;
            od_q <= '0;
        end else if (clocken) begin
            ov_q <= in_v;
            for (int p = 0; p < 2; p++) begin
                if (in_v[p]) begin
                    oo_q[p] <= in_o[p];
                    od_q[p] <= in_d[p];
                end
            end
        end
    end

    assign s1.readdata      = od_q[0];
    assign s1.oor           = oo_q[0];
    assign s1.readdatavalid = ov_q[0] & clocken;
    assign s2.readdata      = od_q[1];
    assign s2.oor           = oo_q[1];
    assign s2.readdatavalid = ov_q[1] & clocken;
endmodule

// File: tb/tb_avmm_dualport_onchip_ram.sv
// tb_avmm_dualport_onchip_ram: drives latency-1 and latency-2 RAMs with identical traffic, scoreboarded against an array model
module tb_avmm_dualport_onchip_ram;
    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DEPTH = 45000;

    typedef struct {
        logic [31:0] d;
        logic        oor;
        int          t;
    } exp_t;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic reset_req = 1'b0;
    logic clken     = 1'b1;
    logic [1:0][AW-1:0] addr;
    logic [1:0]         cs, rd, wr;
    logic [1:0][3:0]    be;
    logic [1:0][31:0]   wd;
    wire  [1:0][1:0][31:0] rdata;
    wire  [1:0][1:0]       rvalid, roor;

    exp_t        q [4][$];
    logic [31:0] mem_m [int];
    int          en_cnt    = 0;
    int          n_run     = 0;
    int          n_fail    = 0;
    bit          chk_zero  = 0;
    bit          final_chk = 0;

    always #5 clk = ~clk;

    for (genvar l = 0; l < 2; l++) begin : g_dut
        avmm_dualport_onchip_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) i1 ();
        avmm_dualport_onchip_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) i2 ();
        assign i1.address    = addr[0];
        assign i1.chipselect = cs[0];
        assign i1.read       = rd[0];
        assign i1.write      = wr[0];
        assign i1.byteenable = be[0];
        assign i1.writedata  = wd[0];
        assign i2.address    = addr[1];
        assign i2.chipselect = cs[1];
        assign i2.read       = rd[1];
        assign i2.write      = wr[1];
        assign i2.byteenable = be[1];
        assign i2.writedata  = wd[1];
        assign rdata[l][0]   = i1.readdata;
        assign rvalid[l][0]  = i1.readdatavalid;
        assign roor[l][0]    = i1.oor;
        assign rdata[l][1]   = i2.readdata;
        assign rvalid[l][1]  = i2.readdatavalid;
        assign roor[l][1]    = i2.oor;
        avmm_dualport_onchip_ram #(
            .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
            .READ_LATENCY(l + 1), .INIT_FILE("UNUSED")
        ) dut (
            .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
            .s1(i1), .s2(i2)
        );
    end

    // stream k: latency k/2+1, port s(k%2+1)
    always @(negedge clk) begin
        if (chk_zero) begin
            for (int k = 0; k < 4; k++) begin
                n_run++;
                if (rdata[k/2][k%2] !== 32'h0 || roor[k/2][k%2] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_out lat%0d s%0d: got data=%h oor=%b, want 0/0", k/2+1, k%2+1, rdata[k/2][k%2], roor[k/2][k%2]);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            while (q[k].size() > 0 && q[k][0].t < en_cnt) void'(q[k].pop_front());
            n_run++;
            if (rvalid[k/2][k%2] !== (q[k].size() > 0 && q[k][0].t == en_cnt && clken && !reset_req)) begin
                n_fail++;
                $display("FAIL valid lat%0d s%0d at t=%0t: got %b, want %b (pending %0d)", k/2+1, k%2+1, $time, rvalid[k/2][k%2], !rvalid[k/2][k%2], q[k].size());
            end else if (rvalid[k/2][k%2]) begin
                n_run++;
                if (rdata[k/2][k%2] !== q[k][0].d || roor[k/2][k%2] !== q[k][0].oor) begin
                    n_fail++;
                    $display("FAIL data lat%0d s%0d at t=%0t: got %h oor=%b, want %h oor=%b", k/2+1, k%2+1, $time, rdata[k/2][k%2], roor[k/2][k%2], q[k][0].d, q[k][0].oor);
                end
                void'(q[k].pop_front());
            end
        end
        if (final_chk) begin
            for (int k = 0; k < 4; k++) begin
                n_run++;
                if (q[k].size() != 0) begin
                    n_fail++;
                    $display("FAIL drain lat%0d s%0d: got %0d results outstanding, want 0", k/2+1, k%2+1, q[k].size());
                end
            end
        end
    end

    task automatic idle();
        cs = '0;
        rd = '0;
        wr = '0;
    endtask

    task automatic set(input int p, input bit r, input bit w, input int a, input logic [3:0] b, input logic [31:0] d);
        cs[p]   = 1'b1;
        rd[p]   = r;
        wr[p]   = w;
        addr[p] = AW'(a);
        be[p]   = b;
        wd[p]   = d;
    endtask

    // one clock: the model applies whatever the DUT accepts at this edge
    task automatic cyc();
        exp_t        e;
        logic [31:0] w;
        int          a;
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < 4; k++) q[k].delete();
        end else if (clken && !reset_req) begin
            for (int p = 0; p < 2; p++) begin
                if (cs[p] && rd[p] && !wr[p]) begin
                    a     = int'(addr[p]);
                    e.oor = a >= DEPTH;
                    e.d   = e.oor ? 32'h0 : mem_m[a];
                    e.t   = en_cnt + 1;
                    q[p].push_back(e);
                    e.t   = en_cnt + 2;
                    q[2+p].push_back(e);
                end
            end
            for (int p = 1; p >= 0; p--) begin
                a = int'(addr[p]);
                if (cs[p] && wr[p] && a < DEPTH) begin
                    w = mem_m.exists(a) ? mem_m[a] : 32'hx;
                    for (int b = 0; b < 4; b++) if (be[p][b]) w[8*b +: 8] = wd[p][8*b +: 8];
                    mem_m[a] = w;
                end
            end
            en_cnt++;
        end
        #1;
    endtask

    initial begin
        idle();
        addr = '0;
        be   = '0;
        wd   = '0;
        repeat (2) cyc();
        reset = 1'b0;
        for (int i = 0; i < 64; i += 2) begin
            idle();
            set(0, 0, 1, i, 4'hF, $urandom);
            set(1, 0, 1, i + 1, 4'hF, $urandom);
            cyc();
        end
        idle(); set(0, 0, 1, 5, 4'hF, 32'hDEADBEEF); cyc();
        idle(); set(0, 1, 0, 5, 4'h0, 32'h0); cyc();
        idle(); set(0, 0, 1, 7, 4'hF, 32'h11223344); cyc();
        idle(); set(0, 0, 1, 7, 4'b0101, 32'hAABBCCDD); cyc();
        idle(); set(0, 1, 0, 7, 4'h0, 32'h0); cyc();
        idle(); set(1, 0, 1, 9, 4'hF, 32'h0); cyc();
        idle(); set(0, 0, 1, 9, 4'b0011, 32'h0000AAAA); set(1, 0, 1, 9, 4'b0110, 32'h00BBBB00); cyc();
        idle(); set(1, 1, 0, 9, 4'h0, 32'h0); cyc();
        idle(); set(0, 0, 1, 5, 4'hF, 32'h12345678); set(1, 1, 0, 5, 4'h0, 32'h0); cyc();
        idle(); set(0, 1, 1, 6, 4'h0, 32'h0); set(1, 0, 1, 8, 4'h0, 32'hFFFFFFFF); cyc();
        idle(); set(1, 1, 0, 45000, 4'h0, 32'h0); cyc();
        idle(); set(1, 0, 1, 45001, 4'hF, 32'hFFFFFFFF); cyc();
        for (int i = 0; i < 4; i++) begin idle(); set(0, 1, 0, i, 4'h0, 32'h0); set(1, 1, 0, 45001 + i, 4'h0, 32'h0); cyc(); end
        for (int i = 1; i <= 3; i++) begin idle(); set(0, 1, 0, i, 4'h0, 32'h0); cyc(); end
        idle(); clken = 1'b0; cyc(); cyc(); clken = 1'b1;
        repeat (3) cyc();
        for (int i = 1; i <= 3; i++) begin idle(); set(1, 1, 0, i, 4'h0, 32'h0); cyc(); end
        idle(); reset_req = 1'b1; cyc(); clken = 1'b0; reset_req = 1'b0; cyc(); clken = 1'b1;
        repeat (3) cyc();
        idle(); set(0, 1, 0, 7, 4'h0, 32'h0); set(1, 1, 0, 45000, 4'h0, 32'h0); cyc();
        idle(); reset = 1'b1; cyc(); reset = 1'b0;
        chk_zero = 1'b1; cyc(); chk_zero = 1'b0;
        idle(); set(0, 1, 0, 7, 4'h0, 32'h0); cyc();
        idle(); repeat (3) cyc();
        repeat (600) begin
            idle();
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(3) != 0) begin
                    int kind = $urandom_range(7);
                    int a = ($urandom_range(9) == 0) ? 45000 + $urandom_range(20535) : $urandom_range(15);
                    set(p, kind < 4 || kind == 7, kind >= 4, a, 4'($urandom), $urandom);
                end
            end
            clken     = $urandom_range(7) != 0;
            reset_req = $urandom_range(15) == 0;
            reset     = $urandom_range(63) == 0;
            cyc();
        end
        idle();
        reset = 1'b0; reset_req = 1'b0; clken = 1'b1;
        repeat (5) cyc();
        final_chk = 1'b1;
        @(negedge clk);
        #1;
        final_chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/avmm_dualport_onchip_ram.md
Name: avmm_dualport_onchip_ram

Overview:
Parametrised Avalon-MM on-chip RAM with two independent slave ports, s1 and s2, on a single clock. It adds the following:
- configurable data width and depth, including depths that are not a power of two
- selectable read latency of 1 or 2, with a readdatavalid output
- out-of-range address detection
- defined byte-lane resolution when both ports write the same word in the same cycle

It sits on the Nios system interconnect as program/data memory. s1 serves the CPU; s2 serves a DMA or debug master.

Parameters:
- DATA_WIDTH, 32, word width in bits; multiple of 8.
- DEPTH, 45000, number of words; addresses >= DEPTH are out of range.
- ADDR_WIDTH, 16, address width; requires 2^ADDR_WIDTH >= DEPTH.
- READ_LATENCY, 1, cycles from read accept to readdatavalid; legal values 1 or 2.
- INIT_FILE, "UNUSED", memory initialisation file; "UNUSED" means contents are undefined at power-up.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- reset_req  in  1  reset-request; stalls the block like clken=0
- clken  in  1  clock enable; clocken = clken & ~reset_req
- sN_address  in  ADDR_WIDTH  word address (N = 1, 2; every sN_ port is duplicated per port)
- sN_chipselect  in  1  port select
- sN_read  in  1  read request
- sN_write  in  1  write request
- sN_byteenable  in  DATA_WIDTH/8  byte-lane enables for writes
- sN_writedata  in  DATA_WIDTH  write data
- sN_readdata  out  DATA_WIDTH  read data
- sN_readdatavalid  out  1  one-cycle pulse; sN_readdata is valid
- sN_oor  out  1  out-of-range flag; qualified by sN_readdatavalid

Behaviour:

Clock and reset
- One clock. Reset is synchronous, active-high, and takes priority over clocken.
- On reset, every sN_readdata, sN_readdatavalid, sN_oor and pipeline valid bit clears to 0. Memory contents are not altered.
- An in-flight read at reset is discarded; no readdatavalid is produced for it.

Request accept (per port, only when clocken=1)
- Write accept: chipselect & write.
- Read accept: chipselect & read & ~write. Write wins when both read and write are asserted; no readdatavalid is produced.
- No waitrequest: every request is accepted in the cycle it is presented with clocken=1.

Writes
- Committed at the clock edge, per byte lane where byteenable=1.
- byteenable=0 means no change to memory.
- Address >= DEPTH: write is dropped silently.

Reads
- Accepted at edge E; sN_readdatavalid is high for exactly one cycle after edge E+READ_LATENCY-1, with sN_readdata valid alongside.
- READ_LATENCY=1: data appears the cycle after accept.
- READ_LATENCY=2: an output register is added, giving one extra cycle.
- Back-to-back reads give a readdatavalid every cycle, in request order.
- Out of range: sN_readdata=0, sN_oor=1 with readdatavalid. Otherwise sN_oor=0.
- sN_readdata holds its last value when readdatavalid=0.

Read-during-write
- Same port, same address: not possible, since write wins.
- Other port, same address, same cycle: the reader returns the OLD data.

Write collision (both ports write the same in-range address in the same cycle)
- Per byte lane, s1 wins where s1_byteenable=1.
- Lanes enabled only on s2 take s2 data.

Stall (clocken=0)
- No accept, no memory write, no pipeline advance; all data and valid stages hold.
- sN_readdatavalid is forced to 0 during stall cycles so no result is presented twice.
- On resume, the pipeline advances. A read stalled mid-pipeline (READ_LATENCY=2) completes with its original data and oor flag.

Test Plan:
- DATA_WIDTH=32, READ_LATENCY=1: s1 writes 0xDEADBEEF to addr 5 with be=4'b1111, then reads addr 5 -> s1_readdatavalid pulses 1 cycle after accept with 0xDEADBEEF, s1_oor=0.
- Byte lanes: write 0x11223344 to addr 7, then be=4'b0101 data 0xAABBCCDD -> read returns 0x11BB33DD.
- Collision: same cycle, s1 writes addr 9 be=0011 data 0x0000AAAA; s2 writes addr 9 be=0110 data 0x00BBBB00 -> read returns 0x00BBAAAA (lane1 from s1, lane2 from s2, lane3 holds prior 0x00).
- DEPTH=45000: s2 reads addr 45000 -> readdatavalid with readdata=0, oor=1. s2 write to addr 45001 leaves addr 45001 mod nothing; subsequent reads of addr 0..3 are unchanged.
- READ_LATENCY=2: back-to-back reads of addr 1, 2, 3 -> readdatavalid on 3 consecutive cycles starting 2 cycles after the first accept, in order. Drop clken for 2 cycles mid-stream -> no duplicate or lost pulses; total of 3 readdatavalid pulses.
- Reset mid-read (READ_LATENCY=2): assert reset the cycle after accept -> no readdatavalid; outputs are 0 the next cycle; memory data is retained (later read returns the prior value).
